alu_exec: RTL
=============

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the request fields are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 The block SHALL have port ALUctl, input, 5 bits: the operation code from the ALU control decoder.
REQ-007 The block SHALL have port op_a, input, XLEN bits: operand A.
REQ-008 The block SHALL have port op_b, input, XLEN bits: operand B; bits [4:0] are the shift amount.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result fields are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port result, output, XLEN bits: the operation result.
REQ-012 The block SHALL have port zero, output, 1 bit: asserted when result equals 0.
REQ-013 The block SHALL have port taken, output, 1 bit: branch decision, equal to zero XOR the latched ALUctl[4].

Function
REQ-014 ALUctl[3:0] SHALL decode as: 0 ADD, 8 SUB, 1 SLL, 2 SLT (signed), 3 SLTU, 4 XOR, 5 SRL, 13 SRA, 6 OR, 7 AND.
- ALUctl[4] selects only the taken inversion, except for code 5'b10000 (REQ-029).
REQ-015 The FSM SHALL have states IDLE, SHIFT and DONE; in_ready SHALL equal 1 only in IDLE.
REQ-016 A request SHALL be accepted when in_valid and in_ready are both 1; ALUctl, op_a and op_b are latched on acceptance.
REQ-017 Non-shift ops SHALL go IDLE->DONE; out_valid rises the cycle after acceptance (latency 1).
REQ-018 SLL, SRL and SRA SHALL go IDLE->SHIFT with count = op_b[4:0].
- Each SHIFT cycle shifts the working register by one bit and decrements count.
- When count reaches 0, the FSM goes to DONE.
- Latency is shamt+1 cycles; shamt 0 goes directly to DONE (latency 1).
REQ-019 SRA SHALL replicate the sign bit of op_a on every step; SRL and SLL SHALL fill with 0.
REQ-020 ADD and SUB SHALL wrap modulo 2^32; SLT and SLTU SHALL produce 0 or 1 in bit 0.
REQ-021 In DONE, result, zero and taken SHALL hold stable until out_ready is 1; the FSM then returns to IDLE.
- No new request is accepted in that same cycle.
REQ-022 Undefined ALUctl codes SHALL produce result 0, zero 1 and taken equal to NOT ALUctl[4], with latency 1.
REQ-023 in_valid while not in IDLE SHALL be ignored, and the request fields SHALL NOT be sampled.

Reset
REQ-024 With reset at a clock edge, the FSM SHALL go to IDLE and any operation in progress SHALL be discarded.
REQ-025 During and after reset: in_ready 1, out_valid 0, result 0, zero 0, taken 0, count 0.
REQ-026 Reset in the SHIFT or DONE state SHALL produce no out_valid pulse for the aborted request.

Configuration
REQ-027 Macro ALU_EXEC_MUL_EN SHALL control the iterative multiplier.
REQ-028 Without ALU_EXEC_MUL_EN, code 5'b10000 SHALL be treated as undefined per REQ-022.
REQ-029 With ALU_EXEC_MUL_EN, code 5'b10000 SHALL select MUL, the low 32 bits of op_a*op_b.
- It uses the additional state MUL: one shift-add step per cycle for 32 cycles, then DONE (latency 33).

Structure
REQ-030 A shared package alu_pkg SHALL hold the ALUctl code constants, the FSM state encoding and XLEN.
REQ-031 One sub-module, alu_comb, SHALL hold the single-cycle operations; alu_exec SHALL hold the FSM, shifter and multiplier.

Verification
REQ-032 ADD: op_a=5, op_b=3 -> result 8, zero 0, out_valid 1 cycle after acceptance.
REQ-033 SUB with ALUctl 5'b11000 (BNE): op_a=op_b=7 -> result 0, zero 1, taken 0.
REQ-034 SRA: op_a=32'h80000000, op_b=4 -> result 32'hF8000000 after 5 cycles; shamt 0 -> result op_a after 1 cycle.
REQ-035 Back-pressure: hold out_ready 0 for 3 cycles -> result stable, in_ready 0; accept again the cycle after the out_ready handshake.
REQ-036 Reset during SHIFT with shamt=20 -> next cycle in_ready 1, out_valid 0; no stale result ever appears.
REQ-037 With ALU_EXEC_MUL_EN: op_a=32'hFFFFFFFF, op_b=2 -> result 32'hFFFFFFFE after 33 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: widths, ALUctl codes,
// FSM state encoding, request payload and small decode/step helpers.
package alu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CTL_W   = 5;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned SHAMT_W = 5;
  // Wide enough to hold the 32 multiplier steps as well as any shift amount.
  localparam int unsigned CNT_W   = 6;

  // ALUctl[3:0] operation codes; ALUctl[4] only inverts the branch decision.
  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd1;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd2;
  localparam logic [OP_W-1:0] OP_SLTU = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd5;
  localparam logic [OP_W-1:0] OP_OR   = 4'd6;
  localparam logic [OP_W-1:0] OP_AND  = 4'd7;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd8;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd13;

  // Full 5-bit code reserved for the iterative multiplier.
  localparam logic [CTL_W-1:0] CTL_MUL = 5'b10000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    MUL   = 2'd3
  } state_t;

  // Which execution path an ALUctl code takes.
  typedef enum logic [1:0] {
    K_COMB  = 2'd0,
    K_SHIFT = 2'd1,
    K_MUL   = 2'd2
  } kind_t;

  // Request payload as presented on the input handshake.
  typedef struct packed {
    logic [CTL_W-1:0] ctl;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
  } alu_req_t;

  // Classify an ALUctl code; the MUL code is special-cased before the low-bit decode.
  function automatic kind_t op_kind(input logic [CTL_W-1:0] ctl);
    kind_t k;
    k = K_COMB;
    if (ctl == CTL_MUL) begin
      k = K_MUL;
    end else begin
      case (ctl[OP_W-1:0])
        OP_SLL, OP_SRL, OP_SRA: k = K_SHIFT;
        default:                k = K_COMB;
      endcase
    end
    return k;
  endfunction

  // One-bit shift step; SRA keeps the sign bit, SLL/SRL fill with zero.
  function automatic logic [XLEN-1:0] shift_step(input logic [OP_W-1:0] op,
                                                 input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    case (op)
      OP_SLL:  r = {v[XLEN-2:0], 1'b0};
      OP_SRA:  r = {v[XLEN-1], v[XLEN-1:1]};
      default: r = {1'b0, v[XLEN-1:1]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations (add/sub/compare/logic). Shift and multiply
// codes, and every undefined code, produce zero here; the iterative
// paths are handled by alu_exec.
module alu_comb (
  input  alu_pkg::alu_req_t          req_i,
  output logic [alu_pkg::XLEN-1:0]   res_o
);

  import alu_pkg::*;

  logic [OP_W-1:0] op;

  // Decode the low opcode bits; the reserved MUL code is never treated as ADD.
  always_comb begin
    res_o = '0;
    op    = req_i.ctl[OP_W-1:0];
    if (req_i.ctl != CTL_MUL) begin
      case (op)
        OP_ADD:  res_o = req_i.a + req_i.b;
        OP_SUB:  res_o = req_i.a - req_i.b;
        OP_SLT:  res_o = XLEN'($signed(req_i.a) < $signed(req_i.b));
        OP_SLTU: res_o = XLEN'(req_i.a < req_i.b);
        OP_XOR:  res_o = req_i.a ^ req_i.b;
        OP_OR:   res_o = req_i.a | req_i.b;
        OP_AND:  res_o = req_i.a & req_i.b;
        default: res_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage with valid/ready handshakes on both sides.
// Single-cycle ops finish one cycle after acceptance; shifts walk one bit
// per cycle (latency shamt+1). Defining ALU_EXEC_MUL_EN adds a 32-step
// shift-add multiplier on ALUctl 5'b10000 (latency 33); otherwise that
// code behaves as undefined (result 0).
module alu_exec #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      ALUctl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            taken
);

  import alu_pkg::*;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [CTL_W-1:0]  ctl_q, ctl_d;
  logic [XLEN-1:0]   work_q, work_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              taken_q, taken_d;

`ifdef ALU_EXEC_MUL_EN
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   mplr_q, mplr_d;
  logic [XLEN-1:0]   acc_sum;
`endif

  alu_req_t          req_c;
  logic [XLEN-1:0]   comb_res_c;
  kind_t             kind_c;
  logic              fin_c;
  logic [XLEN-1:0]   fin_val_c;

  assign req_c = '{ctl: ALUctl, a: op_a, b: op_b};

  alu_comb u_comb (
    .req_i (req_c),
    .res_o (comb_res_c)
  );

  // Next-state, datapath and output-register inputs.
  always_comb begin
    state_d   = state_q;
    ctl_d     = ctl_q;
    work_d    = work_q;
    count_d   = count_q;
    result_d  = result_q;
    zero_d    = zero_q;
    taken_d   = taken_q;
    kind_c    = op_kind(ALUctl);
    fin_c     = 1'b0;
    fin_val_c = '0;
`ifdef ALU_EXEC_MUL_EN
    acc_d     = acc_q;
    mplr_d    = mplr_q;
    acc_sum   = acc_q + (mplr_q[0] ? work_q : '0);
`endif

    case (state_q)
      IDLE: begin
        if (in_valid && ready_q) begin
          ctl_d = ALUctl;
          if (kind_c == K_SHIFT) begin
            if (op_b[SHAMT_W-1:0] == '0) begin
              fin_c     = 1'b1;
              fin_val_c = op_a;
            end else begin
              state_d = SHIFT;
              work_d  = op_a;
              count_d = CNT_W'(op_b[SHAMT_W-1:0]);
            end
`ifdef ALU_EXEC_MUL_EN
          end else if (kind_c == K_MUL) begin
            state_d = MUL;
            work_d  = op_a;
            mplr_d  = op_b;
            acc_d   = '0;
            count_d = CNT_W'(XLEN);
`endif
          end else begin
            fin_c     = 1'b1;
            fin_val_c = comb_res_c;
          end
        end
      end

      SHIFT: begin
        work_d  = shift_step(ctl_q[OP_W-1:0], work_q);
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          fin_c     = 1'b1;
          fin_val_c = work_d;
        end
      end

`ifdef ALU_EXEC_MUL_EN
      MUL: begin
        acc_d   = acc_sum;
        work_d  = {work_q[XLEN-2:0], 1'b0};
        mplr_d  = {1'b0, mplr_q[XLEN-1:1]};
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          fin_c     = 1'b1;
          fin_val_c = acc_sum;
        end
      end
`endif

      DONE: begin
        // Result is held until the consumer takes it; no accept this cycle.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Every path finishes here so zero/taken are always derived the same way.
    if (fin_c) begin
      state_d  = DONE;
      result_d = fin_val_c;
      zero_d   = (fin_val_c == '0);
      taken_d  = (fin_val_c == '0) ^ ctl_d[CTL_W-1];
    end

    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset; reset discards any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      ctl_q    <= '0;
      work_q   <= '0;
      count_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      taken_q  <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      acc_q    <= '0;
      mplr_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      ctl_q    <= ctl_d;
      work_q   <= work_d;
      count_q  <= count_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      taken_q  <= taken_d;
`ifdef ALU_EXEC_MUL_EN
      acc_q    <= acc_d;
      mplr_q   <= mplr_d;
`endif
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign taken     = taken_q;

endmodule
